sram_uart_tx_interface: RTL and testbench

//  Transmit direction of the UART/SRAM link: reads a block of 16-bit words from external SRAM and serialises them on UART_TX_O as 8N1 frames.

---
 rtl/sram_uart_tx_interface_if.sv | 23 ++
 rtl/sram_uart_tx_interface.sv | 175 +++++++++++++++++
 tb/tb_sram_uart_tx_interface.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_uart_tx_interface_if.sv
// Bus bundle between the SRAM->UART transmit block and its requester / SRAM port.
// Signal prefixes are from the transmit block's point of view.
interface sram_uart_tx_interface_if;
    logic        i_start;
    logic [17:0] i_base_address;
    logic [17:0] i_word_count;
    logic [17:0] o_sram_address;
    logic [15:0] i_sram_read_data;
    logic        o_sram_we_n;
    logic        o_uart_tx;
    logic        o_busy;
    logic        o_done;

    modport slave (
        input  i_start, i_base_address, i_word_count, i_sram_read_data,
        output o_sram_address, o_sram_we_n, o_uart_tx, o_busy, o_done
    );

    modport master (
        output i_start, i_base_address, i_word_count, i_sram_read_data,
        input  o_sram_address, o_sram_we_n, o_uart_tx, o_busy, o_done
    );
endinterface

// File: rtl/sram_uart_tx_interface.sv
// Reads Word_count 16-bit words from SRAM and sends each as two 8N1 frames, high byte first.
// The next word is prefetched during the low-byte frame so frames run back-to-back.
module sram_uart_tx_interface #(
    parameter int CLKS_PER_BIT      = 434,
    parameter int SRAM_READ_LATENCY = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    sram_uart_tx_interface_if.slave  bus
);
    localparam int BCW = $clog2(CLKS_PER_BIT + 1);
    localparam int LCW = $clog2(SRAM_READ_LATENCY + 2);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [LCW-1:0] LAT_LAST = LCW'(SRAM_READ_LATENCY);

    typedef enum logic [2:0] {
        S_TX_IDLE,
        S_TX_FETCH,
        S_TX_START,
        S_TX_DATA,
        S_TX_STOP,
        S_TX_FINISH
    } tx_state_t;

    tx_state_t   r_state;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;
    logic [17:0] r_addr;
    logic [17:0] r_words_left;
    logic [BCW-1:0] r_bit_cnt;
    logic [2:0]  r_bit_idx;
    logic [15:0] r_shift;
    logic        r_lo;
    logic [15:0] r_hold;
    logic        r_pf_active;
    logic [LCW-1:0] r_lat_cnt;

    logic [7:0]  w_byte;
    logic        w_data_bit;

    assign w_byte     = r_lo ? r_shift[7:0] : r_shift[15:8];
    assign w_data_bit = w_byte[r_bit_idx];

    // Outputs are registered from the current state, so the line lags the state by one edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_TX_IDLE;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_addr       <= '0;
            r_words_left <= '0;
            r_bit_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_lo         <= 1'b0;
            r_hold       <= '0;
            r_pf_active  <= 1'b0;
            r_lat_cnt    <= '0;
        end else begin
            r_done <= 1'b0;

            if (r_pf_active) begin
                if (r_lat_cnt == LAT_LAST) begin
                    r_hold      <= bus.i_sram_read_data;
                    r_pf_active <= 1'b0;
                end else begin
                    r_lat_cnt <= r_lat_cnt + LCW'(1);
                end
            end

            case (r_state)
                S_TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (bus.i_start) begin
                        r_busy <= 1'b1;
                        if (bus.i_word_count == 18'd0) begin
                            r_state <= S_TX_FINISH;
                        end else begin
                            r_addr       <= bus.i_base_address;
                            r_words_left <= bus.i_word_count;
                            r_lat_cnt    <= '0;
                            r_state      <= S_TX_FETCH;
                        end
                    end
                end

                S_TX_FETCH: begin
                    r_tx <= 1'b1;
                    if (r_lat_cnt == LAT_LAST) begin
                        r_shift   <= bus.i_sram_read_data;
                        r_lo      <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= S_TX_START;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LCW'(1);
                    end
                end

                S_TX_START: begin
                    r_tx <= 1'b0;
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_TX_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                    end
                end

                S_TX_DATA: begin
                    r_tx <= w_data_bit;
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_TX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                    end
                end

                S_TX_STOP: begin
                    r_tx <= 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= '0;
                        if (!r_lo) begin
                            // Low byte follows; launch the next word's read while it is on the line.
                            r_lo    <= 1'b1;
                            r_state <= S_TX_START;
                            if (r_words_left > 18'd1) begin
                                r_addr      <= r_addr + 18'd1;
                                r_lat_cnt   <= '0;
                                r_pf_active <= 1'b1;
                            end
                        end else begin
                            r_words_left <= r_words_left - 18'd1;
                            if (r_words_left > 18'd1) begin
                                r_shift <= r_hold;
                                r_lo    <= 1'b0;
                                r_state <= S_TX_START;
                            end else begin
                                r_state <= S_TX_FINISH;
                            end
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                    end
                end

                S_TX_FINISH: begin
                    r_tx    <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_TX_IDLE;
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_TX_IDLE;
                end
            endcase
        end
    end

    assign bus.o_sram_address = r_addr;
    assign bus.o_sram_we_n    = 1'b1;
    assign bus.o_uart_tx      = r_tx;
    assign bus.o_busy         = r_busy;
    assign bus.o_done         = r_done;
endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Directed and randomized transfers against a word-list/frame-timing reference model
// and a 3-cycle-latency behavioural SRAM.
module tb_sram_uart_tx_interface;
    localparam int C    = 4;
    localparam int L    = 3;
    localparam int SOFS = 2 + L;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_uart_tx_interface_if bus();

    sram_uart_tx_interface #(
        .CLKS_PER_BIT      (C),
        .SRAM_READ_LATENCY (L)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Behavioural SRAM: data for an address appears L cycles after it is presented.
    logic [15:0] mem [int];
    logic [15:0] p1, p2, p3;

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 16'hDEAD;
    endfunction

    always @(posedge clk) begin
        p1 <= mem_rd(bus.o_sram_address);
        p2 <= p1;
        p3 <= p2;
    end
    assign bus.i_sram_read_data = p3;

    int checks = 0;
    int errors = 0;
    int we_bad = 0;
    logic [15:0] ew[$];

    // Expected line level n edges after Start was sampled.
    function automatic logic exp_tx(input int n, input int cnt);
        int m, b, f, pos;
        logic [15:0] w;
        logic [7:0]  by;
        if (n < SOFS || n >= SOFS + 20 * C * cnt) return 1'b1;
        m   = n - SOFS;
        b   = m / C;
        f   = b / 10;
        pos = b % 10;
        w   = ew[f / 2];
        by  = (f % 2 == 0) ? w[15:8] : w[7:0];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[pos - 1];
    endfunction

    task automatic load_exp(input logic [17:0] base, input int cnt);
        ew.delete();
        for (int k = 0; k < cnt; k++) ew.push_back(mem_rd(base + 18'(k)));
    endtask

    task automatic fill(input logic [17:0] base, input int cnt);
        for (int k = 0; k < cnt; k++) mem[int'(base + 18'(k))] = 16'($urandom);
    endtask

    task automatic xfer(input logic [17:0] base, input int cnt, input int poke_at, input string tag);
        int dn, tx_bad, busy_bad, done_bad, first_tx, addr_bad;
        logic [17:0] addrs[$];
        tx_bad = 0; busy_bad = 0; done_bad = 0; first_tx = -1; addr_bad = 0;
        load_exp(base, cnt);
        dn = (cnt == 0) ? 1 : SOFS + 20 * C * cnt;
        @(negedge clk);
        bus.i_start        = 1'b1;
        bus.i_base_address = base;
        bus.i_word_count   = 18'(cnt);
        for (int n = 0; n < dn + 4; n++) begin
            @(negedge clk);
            bus.i_start        = 1'b0;
            bus.i_base_address = 18'($urandom);
            bus.i_word_count   = 18'($urandom_range(1, 9));
            if (bus.o_uart_tx !== exp_tx(n, cnt)) begin
                if (first_tx < 0) first_tx = n;
                tx_bad++;
            end
            if (bus.o_busy !== (n < dn)) busy_bad++;
            if (bus.o_done !== (n == dn)) done_bad++;
            if (bus.o_sram_we_n !== 1'b1) we_bad++;
            if (cnt > 0 && n < dn && (addrs.size() == 0 || bus.o_sram_address !== addrs[$]))
                addrs.push_back(bus.o_sram_address);
            if (n == poke_at) begin
                bus.i_start        = 1'b1;
                bus.i_base_address = base ^ 18'h00155;
                bus.i_word_count   = 18'd7;
            end
        end
        checks++;
        assert (tx_bad === 0) else begin
            errors++;
            $error("FAIL %s tx: %0d wrong cycles (first at edge %0d), required 0", tag, tx_bad, first_tx);
        end
        checks++;
        assert (busy_bad === 0) else begin
            errors++;
            $error("FAIL %s busy: %0d wrong cycles, required 0 (high for %0d cycles)", tag, busy_bad, dn);
        end
        checks++;
        assert (done_bad === 0) else begin
            errors++;
            $error("FAIL %s done: %0d wrong cycles, required single pulse at edge %0d", tag, done_bad, dn);
        end
        if (cnt > 0) begin
            if (addrs.size() != cnt) addr_bad++;
            for (int k = 0; k < addrs.size() && k < cnt; k++)
                if (addrs[k] !== base + 18'(k)) addr_bad++;
            checks++;
            assert (addr_bad === 0) else begin
                errors++;
                $error("FAIL %s addr: %0d distinct addresses with %0d wrong, required %0d from %05h",
                       tag, addrs.size(), addr_bad, cnt, base);
            end
        end
    endtask

    initial begin
        logic [17:0] rb;
        int rc, pre_bad, post_bad;

        bus.i_start        = 1'b0;
        bus.i_base_address = '0;
        bus.i_word_count   = '0;
        repeat (3) @(negedge clk);
        checks++;
        assert (bus.o_uart_tx === 1'b1) else begin errors++; $error("FAIL rst_tx got %b want 1", bus.o_uart_tx); end
        checks++;
        assert (bus.o_busy === 1'b0) else begin errors++; $error("FAIL rst_busy got %b want 0", bus.o_busy); end
        checks++;
        assert (bus.o_done === 1'b0) else begin errors++; $error("FAIL rst_done got %b want 0", bus.o_done); end
        checks++;
        assert (bus.o_sram_address === 18'd0) else begin errors++; $error("FAIL rst_addr got %05h want 00000", bus.o_sram_address); end
        checks++;
        assert (bus.o_sram_we_n === 1'b1) else begin errors++; $error("FAIL rst_we_n got %b want 1", bus.o_sram_we_n); end
        rst = 1'b0;
        @(negedge clk);

        mem[32'h10] = 16'hA55A;
        xfer(18'h00010, 1, -1, "t1_single");

        mem[32'h200] = 16'h0102; mem[32'h201] = 16'h0304; mem[32'h202] = 16'h0506;
        xfer(18'h00200, 3, -1, "t2_three");

        xfer(18'h00055, 0, -1, "t3_zero");

        fill(18'h3FFFF, 1); fill(18'h00000, 1);
        xfer(18'h3FFFF, 2, -1, "t4_wrap");

        fill(18'h01234, 2);
        xfer(18'h01234, 2, 30, "t5_restart");

        // Reset in the middle of d3 of the first frame.
        rb = 18'h00777;
        fill(rb, 2);
        load_exp(rb, 2);
        pre_bad = 0; post_bad = 0;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_base_address = rb; bus.i_word_count = 18'd2;
        for (int n = 0; n < 22; n++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            if (bus.o_uart_tx !== exp_tx(n, 2)) pre_bad++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        assert (pre_bad === 0) else begin errors++; $error("FAIL t6_pre tx: %0d wrong cycles, required 0", pre_bad); end
        checks++;
        assert (bus.o_uart_tx === 1'b1) else begin errors++; $error("FAIL t6_tx got %b want 1", bus.o_uart_tx); end
        checks++;
        assert (bus.o_busy === 1'b0) else begin errors++; $error("FAIL t6_busy got %b want 0", bus.o_busy); end
        checks++;
        assert (bus.o_done === 1'b0) else begin errors++; $error("FAIL t6_done got %b want 0", bus.o_done); end
        for (int n = 0; n < 8; n++) begin
            if (n == 2) rst = 1'b0;
            @(negedge clk);
            if (bus.o_done !== 1'b0 || bus.o_uart_tx !== 1'b1 || bus.o_busy !== 1'b0) post_bad++;
        end
        checks++;
        assert (post_bad === 0) else begin errors++; $error("FAIL t6_quiet: %0d active cycles after reset, required 0", post_bad); end
        fill(18'h00900, 2);
        xfer(18'h00900, 2, -1, "t6_after");

        for (int i = 0; i < 6; i++) begin
            rb = (i % 2 == 0) ? 18'($urandom) : 18'h3FFFF - 18'($urandom_range(0, 2));
            rc = $urandom_range(0, 3);
            fill(rb, rc);
            xfer(rb, rc, (i == 3) ? 50 : -1, "rand");
        end

        checks++;
        assert (we_bad === 0) else begin errors++; $error("FAIL we_n: %0d cycles low, required 0", we_bad); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
